// File: rtl/pdp8_pkg.sv
// PDP-8 shared widths and arbiter types. ADDR_WIDTH/DATA_WIDTH may be pre-defined by the build.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    localparam int PDP8_ADDR_W    = `ADDR_WIDTH;
    localparam int PDP8_DATA_W    = `DATA_WIDTH;
    localparam int MEM_RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_ACK
    } arb_state_e;

    typedef enum logic {
        ARB_IFU,
        ARB_EXE
    } arb_id_e;

endpackage

// File: rtl/pdp8_arb_pick.sv
// Combinational winner select between IFU and EXE.
// MEM_ARB_RR_EN selects round-robin; otherwise EXE has fixed priority over IFU.
module pdp8_arb_pick
    import pdp8_pkg::*;
(
    input  logic    ifu_req,
    input  logic    exe_req,
`ifdef MEM_ARB_RR_EN
    input  arb_id_e last_id,
`endif
    output logic    grant,
    output arb_id_e grant_id
);

    always_comb begin
        grant    = ifu_req | exe_req;
        grant_id = ARB_EXE;
`ifdef MEM_ARB_RR_EN
        // On a tie the unit that was not served last goes first.
        if (ifu_req && exe_req)
            grant_id = (last_id == ARB_EXE) ? ARB_IFU : ARB_EXE;
        else if (ifu_req)
            grant_id = ARB_IFU;
`else
        if (ifu_req && !exe_req)
            grant_id = ARB_IFU;
`endif
    end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Single-port PDP-8 memory arbiter between IFU (read) and EXE (read/write), one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed EXE>IFU priority.
module pdp8_mem_arbiter
    import pdp8_pkg::*;
#(
    parameter int ADDR_W = PDP8_ADDR_W,
    parameter int DATA_W = PDP8_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ifu_rd_req,
    input  logic [ADDR_W-1:0] ifu_rd_addr,
    output logic              ifu_ack,
    output logic [DATA_W-1:0] ifu_rd_data,
    input  logic              exe_rd_req,
    input  logic              exe_wr_req,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wr_data,
    output logic              exe_ack,
    output logic [DATA_W-1:0] exe_rd_data,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              protocol_err
);

    localparam int               CNT_W     = $clog2(MEM_RD_LAT_MAX);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 2);

    arb_state_e        state;
    arb_id_e           lat_id;
    logic              lat_wr;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] ifu_hold;
    logic [DATA_W-1:0] exe_hold;
    logic              exe_req;
    logic              grant;
    arb_id_e           grant_id;

    assign exe_req = exe_rd_req | exe_wr_req;

`ifdef MEM_ARB_RR_EN
    arb_id_e last_id;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n)
            last_id <= ARB_EXE;
        else if (state == ARB_IDLE && grant)
            last_id <= grant_id;
    end

    pdp8_arb_pick u_pick (
        .ifu_req  (ifu_rd_req),
        .exe_req  (exe_req),
        .last_id  (last_id),
        .grant    (grant),
        .grant_id (grant_id)
    );
`else
    pdp8_arb_pick u_pick (
        .ifu_req  (ifu_rd_req),
        .exe_req  (exe_req),
        .grant    (grant),
        .grant_id (grant_id)
    );
`endif

    // NOTE: state and outputs update with <= so every branch sees pre-edge values; the
    // asynchronous reset is on the rising edge of reset_n because this codebase's reset is active-high.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state        <= ARB_IDLE;
            lat_id       <= ARB_IFU;
            lat_wr       <= 1'b0;
            wait_cnt     <= '0;
            ifu_hold     <= '0;
            exe_hold     <= '0;
            ifu_ack      <= 1'b0;
            exe_ack      <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_rd_addr  <= '0;
            mem_wr_req   <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (exe_rd_req && exe_wr_req)
                protocol_err <= 1'b1;

            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        lat_id <= grant_id;
                        state  <= ARB_ISSUE;
                        if (grant_id == ARB_EXE) begin
                            // A simultaneous read and write resolves to the write.
                            lat_wr     <= exe_wr_req;
                            mem_rd_req <= ~exe_wr_req;
                            mem_wr_req <= exe_wr_req;
                            if (exe_wr_req) begin
                                mem_wr_addr <= exe_addr;
                                mem_wr_data <= exe_wr_data;
                            end else begin
                                mem_rd_addr <= exe_addr;
                            end
                        end else begin
                            lat_wr      <= 1'b0;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= ifu_rd_addr;
                        end
                    end
                end

                ARB_ISSUE: begin
                    mem_rd_req <= 1'b0;
                    mem_wr_req <= 1'b0;
                    wait_cnt   <= WAIT_INIT;
                    if (lat_wr || RD_LAT == 1) begin
                        state   <= ARB_ACK;
                        ifu_ack <= (lat_id == ARB_IFU);
                        exe_ack <= (lat_id == ARB_EXE);
                    end else begin
                        state <= ARB_WAIT;
                    end
                end

                ARB_WAIT: begin
                    if (wait_cnt == '0) begin
                        state   <= ARB_ACK;
                        ifu_ack <= (lat_id == ARB_IFU);
                        exe_ack <= (lat_id == ARB_EXE);
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                ARB_ACK: begin
                    ifu_ack <= 1'b0;
                    exe_ack <= 1'b0;
                    state   <= ARB_IDLE;
                    if (!lat_wr) begin
                        if (lat_id == ARB_IFU)
                            ifu_hold <= mem_rd_data;
                        else
                            exe_hold <= mem_rd_data;
                    end
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Memory data is only valid during the ACK cycle, so it is forwarded then and held afterwards.
    assign ifu_rd_data = ifu_ack             ? mem_rd_data : ifu_hold;
    assign exe_rd_data = (exe_ack && !lat_wr) ? mem_rd_data : exe_hold;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Self-checking bench for pdp8_mem_arbiter: RD_LAT=1 vector table plus RD_LAT=3 sequences.
`timescale 1ns/1ps
module tb_pdp8_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_ifu_rd_req, a_ifu_ack, a_exe_rd_req, a_exe_wr_req, a_exe_ack;
    logic        a_mem_rd_req, a_mem_wr_req, a_perr;
    logic [11:0] a_ifu_rd_addr, a_ifu_rd_data, a_exe_addr, a_exe_wr_data, a_exe_rd_data;
    logic [11:0] a_mem_rd_addr, a_mem_rd_data, a_mem_wr_addr, a_mem_wr_data;

    logic        b_ifu_rd_req, b_ifu_ack, b_exe_rd_req, b_exe_wr_req, b_exe_ack;
    logic        b_mem_rd_req, b_mem_wr_req, b_perr;
    logic [11:0] b_ifu_rd_addr, b_ifu_rd_data, b_exe_addr, b_exe_wr_data, b_exe_rd_data;
    logic [11:0] b_mem_rd_addr, b_mem_rd_data, b_mem_wr_addr, b_mem_wr_data;

    pdp8_mem_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .ifu_rd_req(a_ifu_rd_req), .ifu_rd_addr(a_ifu_rd_addr), .ifu_ack(a_ifu_ack), .ifu_rd_data(a_ifu_rd_data),
        .exe_rd_req(a_exe_rd_req), .exe_wr_req(a_exe_wr_req), .exe_addr(a_exe_addr), .exe_wr_data(a_exe_wr_data),
        .exe_ack(a_exe_ack), .exe_rd_data(a_exe_rd_data),
        .mem_rd_req(a_mem_rd_req), .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data),
        .mem_wr_req(a_mem_wr_req), .mem_wr_addr(a_mem_wr_addr), .mem_wr_data(a_mem_wr_data),
        .protocol_err(a_perr)
    );

    pdp8_mem_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LAT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .ifu_rd_req(b_ifu_rd_req), .ifu_rd_addr(b_ifu_rd_addr), .ifu_ack(b_ifu_ack), .ifu_rd_data(b_ifu_rd_data),
        .exe_rd_req(b_exe_rd_req), .exe_wr_req(b_exe_wr_req), .exe_addr(b_exe_addr), .exe_wr_data(b_exe_wr_data),
        .exe_ack(b_exe_ack), .exe_rd_data(b_exe_rd_data),
        .mem_rd_req(b_mem_rd_req), .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data),
        .mem_wr_req(b_mem_wr_req), .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data),
        .protocol_err(b_perr)
    );

    // Shared memory model; unwritten words read a fixed pattern, invalid cycles read 'o6666.
    logic [11:0] mem [0:4095];
    bit          written [0:4095];
    bit          a_pv;
    logic [11:0] a_pa;
    bit   [2:0]  b_pv;
    logic [11:0] b_pa [0:2];

    function automatic logic [11:0] init_word(input logic [11:0] a);
        case (a)
            12'o0200: return 12'o7402;
            12'o0300: return 12'o5555;
            default:  return ~a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (a_mem_wr_req) begin
            mem[a_mem_wr_addr]     <= a_mem_wr_data;
            written[a_mem_wr_addr] <= 1'b1;
        end
        if (b_mem_wr_req) begin
            mem[b_mem_wr_addr]     <= b_mem_wr_data;
            written[b_mem_wr_addr] <= 1'b1;
        end
        a_pv    <= a_mem_rd_req;
        a_pa    <= a_mem_rd_addr;
        b_pv    <= {b_pv[1:0], b_mem_rd_req};
        b_pa[0] <= b_mem_rd_addr;
        b_pa[1] <= b_pa[0];
        b_pa[2] <= b_pa[1];
    end

    always_comb begin
        a_mem_rd_data = 12'o6666;
        if (a_pv) a_mem_rd_data = written[a_pa] ? mem[a_pa] : init_word(a_pa);
        b_mem_rd_data = 12'o6666;
        if (b_pv[2]) b_mem_rd_data = written[b_pa[2]] ? mem[b_pa[2]] : init_word(b_pa[2]);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Bit c of each mask is the expected value in cycle c after the request cycle.
    typedef struct {
        string       name;
        logic        ifu_req;
        logic [11:0] ifu_addr;
        logic        exe_rd;
        logic        exe_wr;
        logic [11:0] exe_addr;
        logic [11:0] exe_wdata;
        logic [7:0]  rd_mask;
        logic [7:0]  wr_mask;
        logic [7:0]  ifu_ack_mask;
        logic [7:0]  exe_ack_mask;
        logic [11:0] addr1;
        logic [11:0] ifu_data;
        logic [11:0] exe_data;
        logic        perr;
    } vec_t;

    function automatic vec_t mk(input string n, input logic ir, input logic [11:0] ia,
                                input logic er, input logic ew, input logic [11:0] ea, input logic [11:0] ed,
                                input logic [7:0] rm, input logic [7:0] wm, input logic [7:0] iam,
                                input logic [7:0] eam, input logic [11:0] a1, input logic [11:0] id,
                                input logic [11:0] xd, input logic pe);
        vec_t v;
        v.name = n; v.ifu_req = ir; v.ifu_addr = ia; v.exe_rd = er; v.exe_wr = ew;
        v.exe_addr = ea; v.exe_wdata = ed; v.rd_mask = rm; v.wr_mask = wm;
        v.ifu_ack_mask = iam; v.exe_ack_mask = eam; v.addr1 = a1;
        v.ifu_data = id; v.exe_data = xd; v.perr = pe;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [7:0] rd_m, wr_m, ia_m, ea_m;
        rd_m = '0; wr_m = '0; ia_m = '0; ea_m = '0;
        @(negedge clk);
        a_ifu_rd_req = v.ifu_req; a_ifu_rd_addr = v.ifu_addr;
        a_exe_rd_req = v.exe_rd;  a_exe_wr_req  = v.exe_wr;
        a_exe_addr   = v.exe_addr; a_exe_wr_data = v.exe_wdata;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            rd_m[c] = a_mem_rd_req; wr_m[c] = a_mem_wr_req;
            ia_m[c] = a_ifu_ack;    ea_m[c] = a_exe_ack;
            check({v.name, " strobe overlap"}, 32'(a_mem_rd_req & a_mem_wr_req), 0);
            if (c == 1)
                check({v.name, " first addr"}, a_mem_wr_req ? a_mem_wr_addr : a_mem_rd_addr, v.addr1);
            if (a_mem_wr_req)
                check({v.name, " wr data"}, a_mem_wr_data, v.exe_wdata);
            if (a_ifu_ack) begin
                check({v.name, " ifu data at ack"}, a_ifu_rd_data, v.ifu_data);
                a_ifu_rd_req = 1'b0;
            end
            if (a_exe_ack) begin
                check({v.name, " exe data at ack"}, a_exe_rd_data, v.exe_data);
                a_exe_rd_req = 1'b0;
                a_exe_wr_req = 1'b0;
            end
        end
        check({v.name, " rd strobes"}, rd_m, v.rd_mask);
        check({v.name, " wr strobes"}, wr_m, v.wr_mask);
        check({v.name, " ifu acks"}, ia_m, v.ifu_ack_mask);
        check({v.name, " exe acks"}, ea_m, v.exe_ack_mask);
        check({v.name, " ifu data held"}, a_ifu_rd_data, v.ifu_data);
        check({v.name, " exe data held"}, a_exe_rd_data, v.exe_data);
        check({v.name, " protocol_err"}, a_perr, v.perr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [7];
        logic [7:0] rd_m, wr_m, ia_m, ea_m;
        logic       ack_seen;

        vecs[0] = mk("ifu_rd",  1, 12'o0200, 0, 0, 12'o0000, 12'o0000,
                     8'h02, 8'h00, 8'h04, 8'h00, 12'o0200, 12'o7402, 12'o0000, 0);
        vecs[1] = mk("exe_wr",  0, 12'o0000, 0, 1, 12'o0010, 12'o1234,
                     8'h00, 8'h02, 8'h00, 8'h04, 12'o0010, 12'o7402, 12'o0000, 0);
        vecs[2] = mk("exe_rd",  0, 12'o0000, 1, 0, 12'o0010, 12'o0000,
                     8'h02, 8'h00, 8'h00, 8'h04, 12'o0010, 12'o7402, 12'o1234, 0);
`ifdef MEM_ARB_RR_EN
        vecs[3] = mk("tie_rr",  1, 12'o0010, 1, 0, 12'o0300, 12'o0000,
                     8'h12, 8'h00, 8'h04, 8'h20, 12'o0010, 12'o1234, 12'o5555, 0);
`else
        vecs[3] = mk("tie_fix", 1, 12'o0010, 1, 0, 12'o0300, 12'o0000,
                     8'h12, 8'h00, 8'h20, 8'h04, 12'o0300, 12'o1234, 12'o5555, 0);
`endif
        vecs[4] = mk("rd_wr_both", 0, 12'o0000, 1, 1, 12'o0020, 12'o4321,
                     8'h00, 8'h02, 8'h00, 8'h04, 12'o0020, 12'o1234, 12'o5555, 1);
        vecs[5] = mk("exe_rd2", 0, 12'o0000, 1, 0, 12'o0020, 12'o0000,
                     8'h02, 8'h00, 8'h00, 8'h04, 12'o0020, 12'o1234, 12'o4321, 1);
        vecs[6] = mk("ifu_rd2", 1, 12'o0020, 0, 0, 12'o0000, 12'o0000,
                     8'h02, 8'h00, 8'h04, 8'h00, 12'o0020, 12'o4321, 12'o4321, 1);

        reset_n = 1'b1;
        a_ifu_rd_req = 0; a_ifu_rd_addr = '0; a_exe_rd_req = 0; a_exe_wr_req = 0;
        a_exe_addr = '0; a_exe_wr_data = '0;
        b_ifu_rd_req = 0; b_ifu_rd_addr = '0; b_exe_rd_req = 0; b_exe_wr_req = 0;
        b_exe_addr = '0; b_exe_wr_data = '0;
        repeat (3) @(negedge clk);

        check("reset a strobes", {a_ifu_ack, a_exe_ack, a_mem_rd_req, a_mem_wr_req, a_perr}, 0);
        check("reset a data", {a_ifu_rd_data, a_exe_rd_data}, 0);
        check("reset a mem bus", {a_mem_rd_addr, a_mem_wr_addr}, 0);
        check("reset a wr data", a_mem_wr_data, 0);
        check("reset b strobes", {b_ifu_ack, b_exe_ack, b_mem_rd_req, b_mem_wr_req, b_perr}, 0);
        check("reset b data", {b_ifu_rd_data, b_exe_rd_data}, 0);
        reset_n = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // RD_LAT=3 EXE read: ack exactly four cycles after the request cycle, no strobes in WAIT.
        rd_m = '0; wr_m = '0; ia_m = '0; ea_m = '0;
        @(negedge clk);
        b_exe_rd_req = 1'b1; b_exe_addr = 12'o0300;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            rd_m[c] = b_mem_rd_req; wr_m[c] = b_mem_wr_req;
            ia_m[c] = b_ifu_ack;    ea_m[c] = b_exe_ack;
            if (b_exe_ack) begin
                check("lat3 exe data at ack", b_exe_rd_data, 12'o5555);
                b_exe_rd_req = 1'b0;
            end
        end
        check("lat3 rd strobes", rd_m, 8'h02);
        check("lat3 wr strobes", wr_m, 8'h00);
        check("lat3 exe acks", ea_m, 8'h10);
        check("lat3 ifu acks", ia_m, 8'h00);

        // Reset during WAIT: outputs clear at once, no ack, late read data ignored.
        @(negedge clk);
        b_ifu_rd_req = 1'b1; b_ifu_rd_addr = 12'o0200;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midreset b strobes", {b_ifu_ack, b_exe_ack, b_mem_rd_req, b_mem_wr_req, b_perr}, 0);
        check("midreset b data", {b_ifu_rd_data, b_exe_rd_data}, 0);
        check("midreset b mem addr", b_mem_rd_addr, 0);
        check("midreset a protocol_err", a_perr, 0);
        check("midreset a data", {a_ifu_rd_data, a_exe_rd_data}, 0);
        ack_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ack_seen = ack_seen | b_ifu_ack | b_exe_ack | b_mem_rd_req;
        end
        check("midreset activity during reset", ack_seen, 0);
        reset_n = 1'b0;
        rd_m = '0; ia_m = '0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            rd_m[c] = b_mem_rd_req; ia_m[c] = b_ifu_ack;
            if (b_ifu_ack) begin
                check("postreset ifu data at ack", b_ifu_rd_data, 12'o7402);
                b_ifu_rd_req = 1'b0;
            end
        end
        check("postreset rd strobes", rd_m, 8'h02);
        check("postreset ifu acks", ia_m, 8'h10);
        check("postreset protocol_err", b_perr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
